// File: rtl/fmul_share_arbiter_if.sv
// Bundle of every handshake and datapath signal around fmul_share_arbiter.
//   req0_* / req1_*  : requester side (valid/ready, 64-bit operands, round mode)
//   mul_*            : shared pipelined double multiplier (operands, round, result, flag)
//   rsp0_* / rsp1_*  : per-requester response FIFO heads (valid/ready, data, flag)
// slave  : the arbiter's view.
// master : the environment's view (requesters, consumers and the multiplier).
interface fmul_share_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [63:0] req0_a;
  logic [63:0] req0_b;
  logic        req0_round;
  logic        req1_valid;
  logic        req1_ready;
  logic [63:0] req1_a;
  logic [63:0] req1_b;
  logic        req1_round;
  logic [63:0] mul_ina;
  logic [63:0] mul_inb;
  logic        mul_round_cfg;
  logic [63:0] mul_out;
  logic [1:0]  mul_flag;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [63:0] rsp0_data;
  logic [1:0]  rsp0_flag;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [63:0] rsp1_data;
  logic [1:0]  rsp1_flag;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_round,
    input  req1_valid, req1_a, req1_b, req1_round,
    input  mul_out, mul_flag, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, mul_ina, mul_inb, mul_round_cfg,
    output rsp0_valid, rsp0_data, rsp0_flag, rsp1_valid, rsp1_data, rsp1_flag
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_round,
    output req1_valid, req1_a, req1_b, req1_round,
    output mul_out, mul_flag, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, mul_ina, mul_inb, mul_round_cfg,
    input  rsp0_valid, rsp0_data, rsp0_flag, rsp1_valid, rsp1_data, rsp1_flag
  );
endinterface

// File: rtl/fmul_share_arbiter.sv
// Round-robin sharing of one fixed-latency double multiplier between two
// requesters. Each issue carries a {valid, id, round} tag down a LAT+1 deep
// pipe; the round bit is re-timed onto mul_round_cfg for the multiplier's
// final stage, and the tag steers {mul_out, mul_flag} into the issuing
// requester's response FIFO. Per-requester credits (FIFO occupancy plus
// in-flight tags) stop issue before a FIFO could overflow.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      fmul_share_arbiter_if.slave (requests, multiplier, responses)
module fmul_share_arbiter #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  fmul_share_arbiter_if.slave bus
);

  localparam int unsigned   CW       = $clog2(DEPTH + 1);
  localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  typedef struct packed {
    logic v;
    logic id;
    logic rnd;
  } tag_t;

  logic [1:0]    req_v, req_rnd, rsp_rdy;
  logic [63:0]   req_a [2];
  logic [63:0]   req_b [2];
  logic [1:0]    elig, grant, push, pop, nonempty;
  logic [CW-1:0] cnt [2];
  logic [CW-1:0] occ [2];
  logic [PW-1:0] rd_ptr [2];
  logic [PW-1:0] wr_ptr [2];
  logic [65:0]   mem [2][DEPTH];
  logic [65:0]   head [2];
  logic          rr_last;
  tag_t          t [LAT+1];
  tag_t          issue;
  logic [63:0]   issue_a, issue_b;
  logic          rnd_src;

  assign req_v    = {bus.req1_valid, bus.req0_valid};
  assign req_rnd  = {bus.req1_round, bus.req0_round};
  assign rsp_rdy  = {bus.rsp1_ready, bus.rsp0_ready};
  assign req_a[0] = bus.req0_a;
  assign req_a[1] = bus.req1_a;
  assign req_b[0] = bus.req0_b;
  assign req_b[1] = bus.req1_b;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Grant is a one-hot subset of the valid, credit-eligible requesters;
  // on contention rr_last (last granted id) picks the other one.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < 2; i++) elig[i] = (cnt[i] < CNT_MAX);
    grant = req_v & elig;
    if (grant == 2'b11) grant = rr_last ? 2'b01 : 2'b10;
    issue   = '0;
    issue_a = '0;
    issue_b = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (grant[i]) begin
        issue.v   = 1'b1;
        issue.id  = 1'(i);
        issue.rnd = req_rnd[i];
        issue_a   = req_a[i];
        issue_b   = req_b[i];
      end
    end
  end

  assign bus.req0_ready = reset_n & grant[0];
  assign bus.req1_ready = reset_n & grant[1];

  // Registered one stage ahead of the multiplier's final stage so it is
  // stable while that stage samples it.
  if (LAT == 1) begin : g_rnd_issue
    assign rnd_src = issue.rnd;
  end else begin : g_rnd_tag
    assign rnd_src = t[LAT-2].rnd;
  end

  assign push = {t[LAT].v & t[LAT].id, t[LAT].v & ~t[LAT].id};
  assign pop  = nonempty & rsp_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_last           <= 1'b1;
      bus.mul_ina       <= '0;
      bus.mul_inb       <= '0;
      bus.mul_round_cfg <= 1'b0;
      for (int unsigned k = 0; k <= LAT; k++) t[k] <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        cnt[i]    <= '0;
        occ[i]    <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
    end else begin
      if (issue.v) rr_last <= issue.id;
      bus.mul_ina       <= issue_a;
      bus.mul_inb       <= issue_b;
      bus.mul_round_cfg <= rnd_src;
      t[0] <= issue;
      for (int unsigned k = 1; k <= LAT; k++) t[k] <= t[k-1];
      for (int unsigned i = 0; i < 2; i++) begin
        if (grant[i] && !pop[i])      cnt[i] <= cnt[i] + CW'(1);
        else if (!grant[i] && pop[i]) cnt[i] <= cnt[i] - CW'(1);
        if (push[i] && !pop[i])       occ[i] <= occ[i] + CW'(1);
        else if (!push[i] && pop[i])  occ[i] <= occ[i] - CW'(1);
        if (push[i]) wr_ptr[i] <= ptr_next(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= ptr_next(rd_ptr[i]);
      end
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= {bus.mul_flag, bus.mul_out};
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      nonempty[i] = (occ[i] != '0);
      head[i]     = nonempty[i] ? mem[i][rd_ptr[i]] : '0;
    end
  end

  assign bus.rsp0_valid = nonempty[0];
  assign bus.rsp0_data  = head[0][63:0];
  assign bus.rsp0_flag  = head[0][65:64];
  assign bus.rsp1_valid = nonempty[1];
  assign bus.rsp1_data  = head[1][63:0];
  assign bus.rsp1_flag  = head[1][65:64];

endmodule

// File: doc/fmul_share_arbiter.md
# fmul_share_arbiter

Two-port round-robin arbiter that shares one pipelined double-precision multiplier (fixed latency `LAT`, 64-bit `ina`/`inb`, `round_cfg`, 64-bit `out`, 2-bit over/underflow flag) between two requesters. It issues at most one multiply per cycle and tags each issue with requester ID and round mode. It delays the round bit to line up with the multiplier's final stage, and steers each result plus flag into a per-requester response FIFO. Credit accounting guarantees that no result is ever dropped.

## Interface
- `LAT`, 2: multiplier latency in clock edges from operand capture to registered output.
- `DEPTH`, 4: entries per response FIFO, and the per-requester credit limit.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  grant; a transfer occurs when valid&ready at an edge.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  64  IEEE754 double operands.
- `req0_round` / `req1_round`  in  1  0 = chop, 1 = round-to-nearest.
- `mul_ina`, `mul_inb`  out  64  operands to the multiplier (registered).
- `mul_round_cfg`  out  1  round mode to the multiplier (registered, delayed).
- `mul_out`  in  64  multiplier result.
- `mul_flag`  in  2  multiplier flag: 00 ok, 01 overflow, 10 underflow.
- `rsp0_valid` / `rsp1_valid`  out  1  FIFO head valid.
- `rsp0_ready` / `rsp1_ready`  in  1  consumer accept.
- `rsp0_data` / `rsp1_data`  out  64  result at the FIFO head.
- `rsp0_flag` / `rsp1_flag`  out  2  flag at the FIFO head.

## Operation
- **Credit counter.** `cnt_i` (width clog2(DEPTH+1)) counts FIFO_i occupancy plus in-flight tags for requester i.
  - +1 on issue for i; −1 on rsp_i handshake; unchanged when both occur in the same cycle.
  - `elig_i = (cnt_i < DEPTH)`.
- **Arbitration.** Combinational.
  - Only one requester valid and eligible: that requester is granted.
  - Both valid and eligible: grant goes to the requester not granted last (`rr_last` bit).
  - `rr_last` updates only on an actual transfer.
  - `req_i_ready` may depend combinationally on the req valids and internal state. Requesters must not make valid depend on ready.
  - Once asserted, valid holds with stable operands until accepted.
- **Issue.** On a transfer edge:
  - `mul_ina`/`mul_inb` load the granted operands.
  - Tag stage `t[0]` loads {valid=1, id, round}.
  - In a cycle with no transfer, `mul_ina`/`mul_inb` load 0 and `t[0].valid` loads 0.
- **Tag pipe.** `t[0..LAT]` shifts every cycle with no stall; the multiplier never stalls.
  - `mul_round_cfg` is registered from `t[LAT-2]`'s round bit (the issued bit itself when LAT=1). It therefore holds `t[LAT-1]`'s round bit during the cycle the multiplier's final stage samples it.
- **Writeback.** While `t[LAT].valid`, the next edge writes {`mul_out`, `mul_flag`} into FIFO[`t[LAT].id`].
  - Credits guarantee the FIFO has space; overflow is impossible by construction.
- **FIFOs.** Each is a DEPTH-entry circular buffer with wrapping rd/wr pointers and an occupancy count.
  - `rsp_valid` = occupancy != 0.
  - Push and pop in the same cycle: both take effect and occupancy is unchanged.
  - Push into an empty FIFO: data appears at the head after that edge; there is no bypass.
- **Reset** (assert at any time, including mid-operation), asynchronous:
  - Clears every tag valid, FIFO pointer, occupancy and credit counter.
  - `rr_last` = 1, so req0 wins the first contention.
  - `mul_ina` = `mul_inb` = 0, `mul_round_cfg` = 0.
  - `rsp*_valid` = 0, `rsp*_data` = 0, `rsp*_flag` = 0.
  - In-flight and buffered results are discarded; results emerging from the multiplier after reset are ignored.
  - `req*_ready` reads 0 while `reset_n` = 0.

## Timing
- Handshake at edge E0; operands at the multiplier during E0→E1; multiplier result valid during E0+LAT → E0+LAT+1.
- FIFO write at E0+LAT+1; with LAT=2, `rsp_valid` rises 3 cycles after the request handshake when the FIFO was empty.
- Throughput is one issue per cycle aggregate. A single requester sustains 1/cycle provided its consumer keeps `rsp_ready` = 1.
- `req_i_ready` falls in the cycle `cnt_i` reaches DEPTH. It returns the cycle after a pop drops `cnt_i` below DEPTH, because it follows the registered counter.

## Test plan
- **Single issue.** req0 sends `0x3FF8000000000000` × `0x4000000000000000`, round=0 → `rsp0_valid` 3 cycles later with data `0x4008000000000000`, flag 00; `rsp1_valid` stays 0.
- **Round alignment.** Back-to-back issues of `0x3FF0000000000001` × `0x3FF8000000000000` with round=0 then round=1 → responses `0x3FF8000000000001` then `0x3FF8000000000002`, in order.
- **Contention.** Both valid continuously with both consumers ready → grants alternate req0, req1, req0, …. Each rsp stream returns its own products in issue order.
- **Backpressure.** `rsp0_ready` = 0 while req0 and req1 stay valid:
  - `req0_ready` drops after exactly 4 accepted; req1 then receives every grant.
  - Raising `rsp0_ready` drains 4 results in order and re-grants req0.
- **Flag passthrough.** `0x7FE0000000000000` × `0x7FE0000000000000` → rsp flag 01, routed to the issuing requester only.
- **Mid-flight reset.** Pulse `reset_n` low with 2 results in flight and 2 buffered:
  - All rsp_valid = 0, counters at 0, no stale response after release.
  - The first contended grant goes to req0.
